spi_cfg_regbank: RTL
====================

// Module: spi_cfg_regbank
// PURPOSE
// - Sysclk-domain register bank downstream of the SPI slave. Consumes its address, write data and
//   write-valid pulse; returns read data for MISO shift-out.
// - Holds a shadow copy and an active copy of every effect-module config register. Shadow values
//   move to active only on an audio sample tick, so filter coefficients never change mid-sample.
// PARAMETERS
// - ADDRESS_WIDTH  8   SPI address width incl. R/W bit; block uses [ADDRESS_WIDTH-2:0]
// - DATA_WIDTH     32  register width
// - NUM_MODULES    4   effect modules served, indices 0..NUM_MODULES-1 (max 7)
// - NUM_REGS       4   registers per module, indices 0..NUM_REGS-1 (max 16)
// PORTS
// - i_SYSCLK       in   1                        system clock in user area
// - i_RST          in   1                        synchronous reset, active high
// - i_ADDR         in   ADDRESS_WIDTH-1          [2:0]=module select, [6:3]=register index
// - i_DATA_IN      in   DATA_WIDTH               write data from SPI slave
// - i_DOUT_VALID   in   1                        write strobe from SPI slave; level, rising edge used
// - i_SAMPLE_TICK  in   1                        1-cycle pulse per audio sample
// - o_DATA_OUT     out  DATA_WIDTH               read data to SPI slave shift-out register
// - o_CFG          out  NUM_MODULES*NUM_REGS*DW  active regs; module m, reg r at slice (m*NUM_REGS+r)*DW
// - o_UPDATE       out  NUM_MODULES              1-cycle pulse per module whose active regs were just loaded
// - o_ARMED        out  1                        commit pending, waiting for a sample tick
// BEHAVIOUR
// - Reset: all shadow/active regs 0, o_DATA_OUT 0, o_UPDATE 0, o_ARMED 0, FSM IDLE,
//   commit mask 0, error flag 0, commit counter 0.
// - Write event: i_DOUT_VALID rising edge (registered previous value). Held high gives one write.
//   A pulse raised again after a low cycle is a new write.
// - Write decode, mod=i_ADDR[2:0], reg=i_ADDR[6:3]:
//   - mod<NUM_MODULES and reg<NUM_REGS: shadow[mod][reg] <= i_DATA_IN on the next edge.
//   - mod==7, reg==0 (COMMIT): commit mask |= i_DATA_IN[NUM_MODULES-1:0].
//   - mod==7, reg==1 (STATUS): if i_DATA_IN[1]=1, clear error flag.
//   - Any other address: no state change except sticky error flag <= 1.
// - Read: o_DATA_OUT registered every cycle from i_ADDR, 1-cycle latency.
//   - Valid module/reg returns the shadow value.
//   - mod7/reg0 returns the pending commit mask, zero-extended.
//   - mod7/reg1 returns STATUS: [0]=armed, [1]=error, [15:8]=commit count, rest 0.
//   - Any other address returns 0.
// - Commit FSM:
//   - IDLE: non-zero mask after a COMMIT write -> ARMED. Mask-0 COMMIT write stays IDLE.
//   - ARMED: o_ARMED=1; i_SAMPLE_TICK -> COMMIT.
//   - COMMIT (1 cycle): active[m] <= shadow[m] for each m set in mask; o_UPDATE <= mask
//     (1 cycle, aligned with the new o_CFG); mask <= 0; count <= count+1; -> IDLE.
// - Commit counter is 8 bits and wraps 255->0.
// - Boundaries:
//   - Tick in the same cycle as the COMMIT write is not used; FSM waits for the next tick.
//   - COMMIT write while ARMED ORs into the mask and stays ARMED.
//   - COMMIT write during the COMMIT cycle is kept in the cleared mask; a non-zero result re-arms.
//   - Shadow write during the COMMIT cycle: active gets the pre-write shadow; the new value
//     needs the next commit.
//   - Shadow writes while ARMED are allowed; the committed value is shadow at the COMMIT cycle.
//   - Mask bits >= NUM_MODULES are ignored.
//   - i_RST mid-ARMED or mid-COMMIT returns to reset state next edge; no o_UPDATE pulse.
// TESTING
// - Write 0xDEADBEEF to mod1/reg2, read same addr -> o_DATA_OUT=0xDEADBEEF 1 cycle later;
//   o_CFG slice unchanged (0).
// - Then COMMIT mask 0x2, tick after 5 cycles -> o_ARMED high until the tick; o_UPDATE=4'b0010 for
//   exactly 1 cycle; o_CFG mod1/reg2=0xDEADBEEF; STATUS[15:8]=1.
// - COMMIT mask 0x1 with tick in the same cycle -> no commit. Next tick commits mod0;
//   o_UPDATE=4'b0001.
// - i_DOUT_VALID held high 10 cycles with data 5 to mod0/reg0 -> exactly one write.
//   Write to mod5 -> STATUS[1]=1. STATUS write 0x2 -> STATUS[1]=0.
// - While ARMED, write mod2/reg0=7 and COMMIT 0x4 -> mask reads 0x5; one tick updates mod0 and mod2;
//   o_UPDATE=4'b0101.
// - Assert i_RST while ARMED -> o_ARMED=0, all o_CFG=0, no o_UPDATE. 256 commits -> count wraps to 0.

Source files
------------

// File: rtl/spi_cfg_regbank.sv
// Shadow/active configuration register bank behind the SPI slave. Shadow values
// are copied to the active set only on an audio sample tick, per armed module mask.
module spi_cfg_regbank #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_MODULES   = 4,
  parameter int NUM_REGS      = 4
) (
  input  logic                                   i_SYSCLK,
  input  logic                                   i_RST,
  input  logic [ADDRESS_WIDTH-2:0]               i_ADDR,
  input  logic [DATA_WIDTH-1:0]                  i_DATA_IN,
  input  logic                                   i_DOUT_VALID,
  input  logic                                   i_SAMPLE_TICK,
  output logic [DATA_WIDTH-1:0]                  o_DATA_OUT,
  output logic [NUM_MODULES*NUM_REGS*DATA_WIDTH-1:0] o_CFG,
  output logic [NUM_MODULES-1:0]                 o_UPDATE,
  output logic                                   o_ARMED
);

  localparam int DW = DATA_WIDTH;
  localparam int MW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0] CTRL_MOD = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMMIT} state_t;

  state_t                 r_state, w_state_next;
  logic                   r_valid_d;
  logic [DW-1:0]          r_shadow [NUM_MODULES][NUM_REGS];
  logic [DW-1:0]          r_active [NUM_MODULES][NUM_REGS];
  logic [NUM_MODULES-1:0] r_mask;
  logic [NUM_MODULES-1:0] r_update;
  logic                   r_error;
  logic [7:0]             r_count;
  logic [DW-1:0]          r_data_out;

  logic [2:0]             w_mod;
  logic [3:0]             w_reg;
  logic [MW-1:0]          w_mod_idx;
  logic [RW-1:0]          w_reg_idx;
  logic                   w_addr_cfg, w_addr_commit, w_addr_status;
  logic                   w_wr_evt, w_wr_shadow, w_wr_commit, w_wr_status, w_wr_bad;
  logic [NUM_MODULES-1:0] w_commit_bits;
  logic [DW-1:0]          w_rd_data;

  assign w_mod     = i_ADDR[2:0];
  assign w_reg     = i_ADDR[6:3];
  assign w_mod_idx = w_mod[MW-1:0];
  assign w_reg_idx = w_reg[RW-1:0];

  assign w_addr_cfg    = (w_mod < 3'(NUM_MODULES)) && ({1'b0, w_reg} < 5'(NUM_REGS));
  assign w_addr_commit = (w_mod == CTRL_MOD) && (w_reg == 4'd0);
  assign w_addr_status = (w_mod == CTRL_MOD) && (w_reg == 4'd1);

  // A level held high on the strobe counts as a single write.
  assign w_wr_evt    = i_DOUT_VALID && !r_valid_d;
  assign w_wr_shadow = w_wr_evt && w_addr_cfg;
  assign w_wr_commit = w_wr_evt && w_addr_commit;
  assign w_wr_status = w_wr_evt && w_addr_status;
  assign w_wr_bad    = w_wr_evt && !(w_addr_cfg || w_addr_commit || w_addr_status);

  assign w_commit_bits = w_wr_commit ? i_DATA_IN[NUM_MODULES-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; this is what makes a shadow write in the COMMIT cycle miss that commit.
  always_ff @(posedge i_SYSCLK) begin
    if (i_RST) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if ((r_mask | w_commit_bits) != '0) w_state_next = S_ARMED;
      S_ARMED:  if (i_SAMPLE_TICK) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = (w_commit_bits != '0) ? S_ARMED : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_SYSCLK) begin
    if (i_RST) begin
      r_valid_d  <= 1'b0;
      r_mask     <= '0;
      r_update   <= '0;
      r_error    <= 1'b0;
      r_count    <= 8'd0;
      r_data_out <= '0;
      // NOTE: the register arrays are reset because o_CFG drives live filter settings;
      // they are flop arrays, not RAM, so the reset costs nothing in inference.
      for (int m = 0; m < NUM_MODULES; m++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_shadow[m][r] <= '0;
          r_active[m][r] <= '0;
        end
      end
    end else begin
      r_valid_d  <= i_DOUT_VALID;
      r_data_out <= w_rd_data;
      r_update   <= '0;

      if (w_wr_shadow) r_shadow[w_mod_idx][w_reg_idx] <= i_DATA_IN;

      if (w_wr_bad)                       r_error <= 1'b1;
      else if (w_wr_status && i_DATA_IN[1]) r_error <= 1'b0;

      if (r_state == S_COMMIT) begin
        for (int m = 0; m < NUM_MODULES; m++) begin
          if (r_mask[m]) r_active[m] <= r_shadow[m];
        end
        r_update <= r_mask;
        r_mask   <= w_commit_bits;
        r_count  <= r_count + 8'd1;
      end else begin
        r_mask <= r_mask | w_commit_bits;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_addr_cfg) begin
      w_rd_data = r_shadow[w_mod_idx][w_reg_idx];
    end else if (w_addr_commit) begin
      w_rd_data[NUM_MODULES-1:0] = r_mask;
    end else if (w_addr_status) begin
      w_rd_data[0]    = (r_state == S_ARMED);
      w_rd_data[1]    = r_error;
      w_rd_data[15:8] = r_count;
    end
  end

  always_comb begin
    o_CFG = '0;
    for (int m = 0; m < NUM_MODULES; m++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        o_CFG[(m*NUM_REGS+r)*DW +: DW] = r_active[m][r];
      end
    end
  end

  assign o_DATA_OUT = r_data_out;
  assign o_UPDATE   = r_update;
  assign o_ARMED    = (r_state == S_ARMED);

endmodule
